// File: rtl/bcd_disp_pkg.sv
// Shared segment patterns (gfedcba, active-high) and digit index type for the
// 3-digit BCD display scanner.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int NUM_DIGITS  = 4;
  localparam int NUM_NIBBLES = 3;

  typedef logic [1:0] digit_idx_t;

  function automatic logic nibble_bad(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show "E".
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd3_display_scan.sv
// Captures a 3-digit BCD sum plus carry and scans it onto a 4-digit multiplexed
// 7-segment display with leading-zero blanking and a non-BCD error flag.
module bcd3_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] bcd_in,
  input  logic        carry_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        err
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};

  logic [11:0]      value_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  digit_idx_t       digit_sel_reg;
  logic             err_reg;
  logic [6:0]       seg_reg;
  logic [3:0]       an_reg;

  logic [6:0]       dec_seg [NUM_NIBBLES];
  logic [NUM_NIBBLES-1:0] nib_bad;
  logic             scan_step;
  logic             blank2;
  logic             blank1;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;
  logic             err_next;

  for (genvar gi = 0; gi < NUM_NIBBLES; gi++) begin : g_nibble
    bcd_to_seg7 u_dec (
      .nibble (value_reg[gi*4 +: 4]),
      .seg    (dec_seg[gi])
    );
    assign nib_bad[gi] = nibble_bad(value_reg[gi*4 +: 4]);
  end

  assign scan_step = (cnt_reg == CNT_LAST);
  assign err_next  = |nib_bad;

  // Invalid nibbles are nonzero, so an "E" in a leading position is never hidden.
  assign blank2 = !carry_reg && (value_reg[11:8] == 4'd0);
  assign blank1 = blank2 && (value_reg[7:4] == 4'd0);

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'(1) << digit_sel_reg;
    case (digit_sel_reg)
      2'd0: seg_next = dec_seg[0];
      2'd1: seg_next = blank1 ? SEG_BLANK : dec_seg[1];
      2'd2: seg_next = blank2 ? SEG_BLANK : dec_seg[2];
      2'd3: seg_next = carry_reg ? SEG_1 : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
      carry_reg <= 1'b0;
    end else if (load) begin
      value_reg <= bcd_in;
      carry_reg <= carry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      digit_sel_reg <= '0;
    end else if (scan_step) begin
      cnt_reg       <= '0;
      digit_sel_reg <= digit_sel_reg + 2'd1;
    end else begin
      cnt_reg       <= cnt_reg + CNT_W'(1);
    end
  end

  // Blank digits keep their anode enabled so every digit gets equal dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= SEG_OFF;
      an_reg  <= AN_OFF;
      err_reg <= 1'b0;
    end else begin
      seg_reg <= seg_next ^ SEG_OFF;
      an_reg  <= an_next ^ AN_OFF;
      err_reg <= err_next;
    end
  end

  assign seg       = seg_reg;
  assign an        = an_reg;
  assign digit_sel = digit_sel_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bcd3_display_scan.sv
// Directed-vector bench for bcd3_display_scan with PRESCALE=4, active-high outputs.
module tb_bcd3_display_scan;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1101111;
  localparam logic [6:0] SE = 7'b1111001;
  localparam logic [6:0] SB = 7'b0000000;

  logic        clk;
  logic        rst;
  logic        load;
  logic [11:0] bcd_in;
  logic        carry_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        err;

  int n_vec;
  int n_bad;

  bcd3_display_scan #(.PRESCALE(4), .ACTIVE_LOW(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bcd_in    (bcd_in),
    .carry_in  (carry_in),
    .seg       (seg),
    .an        (an),
    .digit_sel (digit_sel),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic load_val(input logic [11:0] v, input logic c);
    @(negedge clk);
    load = 1'b1; bcd_in = v; carry_in = c;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Align to the first cycle of digit 0's dwell, then check one full scan.
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    int cyc;
    logic [1:0] dsel_exp;
    logic [3:0] an_exp;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    cyc = 0;
    while (an == 4'b0001 && cyc < 40) begin @(negedge clk); cyc++; end
    while (an != 4'b0001 && cyc < 40) begin @(negedge clk); cyc++; end
    check_vec({tag, "_sync_timeout"}, 32'(cyc >= 40), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dsel_exp = 2'(((i + 1) / 4) % 4);
      an_exp   = 4'(1) << (i / 4);
      check_vec($sformatf("%s_c%0d_dsel_an_seg", tag, i), {21'd0, dsel_exp, an_exp, exp_seg[i / 4]},
                {21'd0, digit_sel, an, seg});
      @(negedge clk);
    end
  endtask

  // Caller has just released rst at a negedge.
  task automatic post_reset_checks(input string tag);
    @(negedge clk);
    check_vec({tag, "_e1_an"}, 32'(an), 32'h1);
    check_vec({tag, "_e1_seg"}, 32'(seg), 32'(S0));
    check_vec({tag, "_e1_dsel"}, 32'(digit_sel), 32'd0);
    @(negedge clk);
    check_vec({tag, "_e2_dsel"}, 32'(digit_sel), 32'd0);
    @(negedge clk);
    check_vec({tag, "_e3_dsel"}, 32'(digit_sel), 32'd0);
    @(negedge clk);
    check_vec({tag, "_e4_dsel"}, 32'(digit_sel), 32'd1);
    @(negedge clk);
    check_vec({tag, "_e5_an"}, 32'(an), 32'h2);
    check_vec({tag, "_e5_seg"}, 32'(seg), 32'(SB));
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] d;
    logic [6:0] adv_seg [4];
    int cyc;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; load = 1'b0; bcd_in = '0; carry_in = 1'b0;

    // Reset state and first scan.
    repeat (2) @(negedge clk);
    check_vec("rst_seg", 32'(seg), 32'd0);
    check_vec("rst_an", 32'(an), 32'd0);
    check_vec("rst_dsel", 32'(digit_sel), 32'd0);
    check_vec("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    post_reset_checks("rel");
    scan_check("zero", S0, SB, SB, SB);

    load_val(12'h225, 1'b0);
    scan_check("v225", S5, S2, S2, SB);

    load_val(12'h999, 1'b1);
    check_vec("v1999_err", 32'(err), 32'd0);
    scan_check("v1999", S9, S9, S9, S1);

    load_val(12'h007, 1'b0);
    scan_check("v007", S7, SB, SB, SB);
    load_val(12'h100, 1'b0);
    scan_check("v100", S0, S0, S1, SB);

    // Error flag latency: set after the output edge following capture, then clear.
    @(negedge clk);
    load = 1'b1; bcd_in = 12'h0A3; carry_in = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check_vec("e0A3_err_capture_edge", 32'(err), 32'd0);
    @(negedge clk);
    check_vec("e0A3_err_next_edge", 32'(err), 32'd1);
    scan_check("v0A3", S3, SE, SB, SB);
    load = 1'b1; bcd_in = 12'h003;
    @(negedge clk);
    load = 1'b0;
    check_vec("e003_err_capture_edge", 32'(err), 32'd1);
    @(negedge clk);
    check_vec("e003_err_next_edge", 32'(err), 32'd0);

    // Load landing exactly on a scan-advance edge.
    adv_seg[0] = S8; adv_seg[1] = S6; adv_seg[2] = S4; adv_seg[3] = SB;
    prev = digit_sel;
    cyc = 0;
    while (digit_sel == prev && cyc < 10) begin @(negedge clk); cyc++; end
    check_vec("adv_sync_timeout", 32'(cyc >= 10), 32'd0);
    d = digit_sel;
    repeat (3) @(negedge clk);
    load = 1'b1; bcd_in = 12'h468; carry_in = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check_vec("adv_dsel", 32'(digit_sel), 32'(d + 2'd1));
    @(negedge clk);
    check_vec("adv_an", 32'(an), 32'(4'(1) << (d + 2'd1)));
    check_vec("adv_seg", 32'(seg), 32'(adv_seg[d + 2'd1]));
    scan_check("v468", S8, S6, S4, SB);

    // Reset mid-scan with a simultaneous load: reset wins.
    load_val(12'h999, 1'b1);
    cyc = 0;
    while (digit_sel != 2'd2 && cyc < 20) begin @(negedge clk); cyc++; end
    check_vec("mid_sync_timeout", 32'(cyc >= 20), 32'd0);
    rst = 1'b1; load = 1'b1; bcd_in = 12'h999; carry_in = 1'b1;
    @(negedge clk);
    check_vec("mid_rst_an", 32'(an), 32'd0);
    check_vec("mid_rst_seg", 32'(seg), 32'd0);
    check_vec("mid_rst_dsel", 32'(digit_sel), 32'd0);
    rst = 1'b0; load = 1'b0;
    post_reset_checks("mid");
    scan_check("mid_zero", S0, SB, SB, SB);
    check_vec("mid_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd3_display_scan.md
Name: bcd3_display_scan

Overview:
- Downstream consumer of the 3-digit BCD adder: registers the 12-bit BCD sum plus carry-out and drives a 4-digit time-multiplexed 7-segment display.
- Digit 3 shows the carry ("1"); digits 2..0 show hundreds/tens/units.
- Performs leading-zero blanking and flags non-BCD nibbles.
- Sits between the adder outputs and the board's segment/anode pins.

Parameters:
- PRESCALE, 1000, clock cycles each digit stays lit before the scan advances; legal range >= 2.
- ACTIVE_LOW, 1, when 1 both seg and an are inverted at the output register; when 0 they are active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- load  in  1  capture strobe for bcd_in/carry_in
- bcd_in  in  12  BCD sum: [11:8] hundreds, [7:4] tens, [3:0] units
- carry_in  in  1  adder carry-out; displayed as the thousands digit
- seg  out  7  segment drive, bit order g f e d c b a
- an  out  4  one-hot digit enable; bit i enables digit i
- digit_sel  out  2  index of the digit currently driven
- err  out  1  high while any captured nibble is > 9

Behaviour:
- Single clock domain. Every flop is reset synchronously when rst=1 at a clk edge.
- Reset values (all registered):
  - value 0, carry 0, prescale counter 0, digit_sel 0, err 0.
  - seg and an all inactive: 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.
- Capture:
  - On a clk edge with load=1, bcd_in and carry_in are stored.
  - If load is held high, the value is re-captured on every edge.
  - Outputs reflect a new capture 2 cycles after the load edge (capture register, then output register).
- Scan:
  - The prescale counter counts 0..PRESCALE-1 and wraps.
  - On the cycle it holds PRESCALE-1, digit_sel advances on the next edge: 0->1->2->3->0.
  - seg/an are registered from the current digit_sel and stored value, so they lag digit_sel by one cycle.
  - an is exactly one-hot, or blank-all during reset.
- Decode, per digit in gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any nibble >9 decodes to "E" = 1111001.
- Digit 3 shows "1" when carry=1; otherwise the digit is blanked (seg all inactive, an still asserted for timing uniformity).
- Leading-zero blanking:
  - Digit 2 is blanked if carry=0 and hundreds=0.
  - Digit 1 is blanked if digit 2 is blanked and tens=0.
  - Digit 0 is never blanked.
  - Invalid nibbles count as nonzero.
- err is registered: it is 1 on the cycle after the capture register holds any nibble >9, and clears the same way after a valid load.
- Boundary conditions:
  - load arriving on a scan-advance edge: both take effect; no digit is skipped.
  - rst together with load: rst wins; the value is 0.
  - rst mid-scan: the scan restarts at digit 0 with a fresh full PRESCALE period.
- Maximum displayed value: carry=1 with 999 displays "1999".

Decomposition:
- Package bcd_disp_pkg holds:
  - SEG_0..SEG_9, SEG_E and SEG_BLANK constants (7-bit, gfedcba);
  - a digit-index typedef (2-bit).
- Sub-module bcd_to_seg7: a combinational nibble-to-segment decoder, including the E mapping.
- The top holds the capture register, prescaler, scan counter, blanking logic, polarity inversion and output registers.

Test Plan:
- Use PRESCALE=4, ACTIVE_LOW=0 for all scenarios.
- Reset: hold rst 2 cycles -> seg=0, an=0, digit_sel=0, err=0. First edge after release -> an=0001, seg=0111111 ("0"); digits 1..3 blank.
- load bcd_in=12'h225, carry_in=0 -> after 2 cycles, one scan = 16 cycles shows:
  - an=0001 seg=1101101 (5);
  - an=0010 seg=1011011 (2);
  - an=0100 seg=1011011 (2);
  - an=1000 seg=0000000.
  - digit_sel dwell is 4 cycles each.
- load bcd_in=12'h999, carry_in=1 -> digits 0..3 = 1101111, 1101111, 1101111, 0000110 ("1999"); err=0.
- load bcd_in=12'h007, carry_in=0 -> digit0=0000111; digits 1, 2, 3 blank. Then load 12'h100 -> digits 1 and 0 show 0111111, digit2=0000110.
- load bcd_in=12'h0A3 -> err=1 two cycles after the load edge, digit1=1111001 (E), digit2 blank. A subsequent load of 12'h003 -> err=0 one cycle after capture.
- Reset mid-operation: assert rst while digit_sel=2 with 12'h999 stored -> after release, the display shows a lone "0" on digit 0, and digit_sel stays 0 for 4 full cycles.
